// File: rtl/nco_pkg.sv
// Shared types and helpers for the NCO phase generator.
package nco_pkg;

    // Sideband carried alongside each phase sample down to the sincos output.
    typedef struct packed {
        logic valid;
        logic sync;
    } sideband_t;

    localparam int SB_W = $bits(sideband_t);

    // Half an output LSB expressed in accumulator units; adding it before
    // truncation gives round-half-up. Zero when there are no bits to drop.
    function automatic logic [63:0] half_lsb(input int pw, input int ow);
        if (pw > ow) begin
            return 64'd1 << (pw - ow - 1);
        end
        return 64'd0;
    endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth, non-stalling shift register with asynchronous active-low reset.
module delay_line #(
    parameter int W     = 2,
    parameter int DEPTH = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [DEPTH];

    // Shift every cycle; reset clears all stages so nothing in flight survives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/nco_phase_gen.sv
// Phase accumulator + offset + truncate/round, split into quadrant/angle for
// the CORDIC sincos stage, with a valid/sync sideband delayed to match it.
//
// Handshake: there is no backpressure. en_i=1 in a cycle produces exactly one
// sample, presented on quadrant_o/angle_o with valid_o=1 in the next cycle;
// out_valid_o repeats valid_o LAT cycles later, aligned with sin/cos.
module nco_phase_gen
    import nco_pkg::*;
#(
    parameter int PW       = 32,
    parameter int OW       = 16,
    parameter int ROUND_EN = 0,
    parameter int LAT      = 18
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [PW-1:0] freq_i,
    input  logic          freq_load_i,
    input  logic [PW-1:0] offset_i,
    input  logic          offset_load_i,
    input  logic          en_i,
    input  logic          sync_i,
    output logic [1:0]    quadrant_o,
    output logic [OW-3:0] angle_o,
    output logic          valid_o,
    output logic          sync_o,
    output logic          out_valid_o,
    output logic          out_sync_o
);

    localparam logic [63:0]   HALF64 = half_lsb(PW, OW);
    localparam logic [PW-1:0] RND_K  = (ROUND_EN != 0) ? HALF64[PW-1:0] : '0;

    logic [PW-1:0] acc_q, acc_d;
    logic [PW-1:0] freq_q, freq_d;
    logic [PW-1:0] off_q, off_d;
    logic [OW-1:0] phase_q, phase_d;
    logic          valid_q, valid_d;
    logic          sync_q, sync_d;
    logic          pend_q, pend_d;

    logic [PW-1:0] base;
    logic [PW-1:0] phase_sum;
    logic [PW-1:0] phase_rnd;
    logic [OW-1:0] phase_p;

    // Phase seen by this cycle's sample: a sync forces the sample to phase zero.
    always_comb begin
        base      = sync_i ? '0 : acc_q;
        phase_sum = base + off_q;
        phase_rnd = phase_sum + RND_K;
        phase_p   = OW'(phase_rnd >> (PW - OW));
    end

    // Next-state: accumulator, programmed registers, output sample and sideband.
    always_comb begin
        acc_d   = acc_q;
        freq_d  = freq_q;
        off_d   = off_q;
        phase_d = phase_q;
        valid_d = en_i;
        sync_d  = en_i & (sync_i | pend_q);
        pend_d  = pend_q;

        if (sync_i) begin
            // Restart: the sync sample itself is phase zero, so the next one
            // is one frequency step on.
            acc_d = en_i ? freq_q : '0;
        end else if (en_i) begin
            acc_d = acc_q + freq_q;
        end

        // A sync without a sample is remembered until the next sample marks it.
        if (sync_i && !en_i) begin
            pend_d = 1'b1;
        end else if (en_i) begin
            pend_d = 1'b0;
        end

        if (en_i) begin
            phase_d = phase_p;
        end

        if (freq_load_i) begin
            freq_d = freq_i;
        end
        if (offset_load_i) begin
            off_d = offset_i;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q   <= '0;
            freq_q  <= '0;
            off_q   <= '0;
            phase_q <= '0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            freq_q  <= freq_d;
            off_q   <= off_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            sync_q  <= sync_d;
            pend_q  <= pend_d;
        end
    end

    sideband_t sb_in;
    sideband_t sb_out;

    assign sb_in.valid = valid_q;
    assign sb_in.sync  = sync_q;

    delay_line #(
        .W     (SB_W),
        .DEPTH (LAT)
    ) u_sb_delay (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (sb_in),
        .q_o    (sb_out)
    );

    assign quadrant_o  = phase_q[OW-1 -: 2];
    assign angle_o     = phase_q[OW-3:0];
    assign valid_o     = valid_q;
    assign sync_o      = sync_q;
    assign out_valid_o = sb_out.valid;
    assign out_sync_o  = sb_out.sync;

endmodule

// File: tb/tb_nco_phase_gen.sv
// Bench for nco_phase_gen: a truncating (LAT=18) and a rounding (LAT=4)
// instance share stimulus and are checked against an arithmetic model.
module tb_nco_phase_gen;

    localparam int    PW    = 32;
    localparam int    OW    = 16;
    localparam int    AW    = OW - 2;
    localparam int    LAT0  = 18;
    localparam int    LAT1  = 4;
    localparam longint TWO32 = 64'h1_0000_0000;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic rst_ni = 1'b1;
    always #5 clk = ~clk;

    logic [PW-1:0] freq_i, offset_i;
    logic          freq_load_i, offset_load_i, en_i, sync_i;

    logic [1:0]    quad_w [2];
    logic [AW-1:0] ang_w  [2];
    logic          valid_w [2];
    logic          sync_w  [2];
    logic          ov_w    [2];
    logic          os_w    [2];

    nco_phase_gen #(.PW(PW), .OW(OW), .ROUND_EN(0), .LAT(LAT0)) dut_t (
        .clk_i(clk), .rst_ni(rst_ni),
        .freq_i(freq_i), .freq_load_i(freq_load_i),
        .offset_i(offset_i), .offset_load_i(offset_load_i),
        .en_i(en_i), .sync_i(sync_i),
        .quadrant_o(quad_w[0]), .angle_o(ang_w[0]),
        .valid_o(valid_w[0]), .sync_o(sync_w[0]),
        .out_valid_o(ov_w[0]), .out_sync_o(os_w[0])
    );

    nco_phase_gen #(.PW(PW), .OW(OW), .ROUND_EN(1), .LAT(LAT1)) dut_r (
        .clk_i(clk), .rst_ni(rst_ni),
        .freq_i(freq_i), .freq_load_i(freq_load_i),
        .offset_i(offset_i), .offset_load_i(offset_load_i),
        .en_i(en_i), .sync_i(sync_i),
        .quadrant_o(quad_w[1]), .angle_o(ang_w[1]),
        .valid_o(valid_w[1]), .sync_o(sync_w[1]),
        .out_valid_o(ov_w[1]), .out_sync_o(os_w[1])
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    bit mon_on = 0;

    logic [16:0] samp_q [2][$];  // {sync, phase} per emitted sample
    logic [18:0] cyc_q  [2][$];  // {valid, held phase, out_valid, out_sync} per cycle
    logic [1:0]  sb_q   [2][$];  // sideband history, LAT deep

    longint      m_acc, m_freq, m_off;
    bit          m_pend;
    logic [15:0] m_held [2];

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output phase as the top OW bits of (base + offset [+ half LSB]) mod 2^PW.
    function automatic logic [15:0] ref_phase(input longint base, input longint off, input bit rnd);
        longint s;
        s = (base + off + (rnd ? 64'd32768 : 64'd0)) % TWO32;
        return 16'(s / 65536);
    endfunction

    task automatic model_reset();
        m_acc  = 0;
        m_freq = 0;
        m_off  = 0;
        m_pend = 0;
        for (int d = 0; d < 2; d++) begin
            samp_q[d].delete();
            cyc_q[d].delete();
            sb_q[d].delete();
            repeat (lat_of(d)) sb_q[d].push_back(2'b00);
            m_held[d] = '0;
        end
    endtask

    // Predict what the next clock edge produces from the inputs now driven.
    task automatic tick();
        longint      base;
        bit          s_exp;
        logic [15:0] p;
        logic [1:0]  old;
        base  = sync_i ? 0 : m_acc;
        s_exp = en_i && (sync_i || m_pend);
        for (int d = 0; d < 2; d++) begin
            if (en_i) begin
                p = ref_phase(base, m_off, d == 1);
                m_held[d] = p;
                samp_q[d].push_back({s_exp, p});
            end
            sb_q[d].push_back({en_i, s_exp});
            old = sb_q[d].pop_front();
            cyc_q[d].push_back({en_i, m_held[d], old});
        end
        if (sync_i)    m_acc = en_i ? m_freq : 0;
        else if (en_i) m_acc = (m_acc + m_freq) % TWO32;
        if (sync_i && !en_i) m_pend = 1;
        else if (en_i)       m_pend = 0;
        if (freq_load_i)   m_freq = freq_i;
        if (offset_load_i) m_off  = offset_i;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit fl, input logic [31:0] fv, input bit ol,
                       input logic [31:0] ov, input bit en, input bit sy);
        @(negedge clk);
        #1;
        freq_load_i   = fl;
        freq_i        = fv;
        offset_load_i = ol;
        offset_i      = ov;
        en_i          = en;
        sync_i        = sy;
        tick();
    endtask

    task automatic drive_random();
        freq_load_i   = ($urandom_range(0, 7) == 0);
        freq_i        = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 32'h0004_0000)) : 32'($urandom);
        offset_load_i = ($urandom_range(0, 7) == 0);
        offset_i      = 32'($urandom);
        en_i          = ($urandom_range(0, 3) != 0);
        sync_i        = ($urandom_range(0, 15) == 0);
    endtask

    task automatic rand_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            drive_random();
            tick();
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_quadrant_dut%0d", tag, d), quad_w[d], 0);
            check($sformatf("%s_angle_dut%0d", tag, d), ang_w[d], 0);
            check($sformatf("%s_valid_dut%0d", tag, d), valid_w[d], 0);
            check($sformatf("%s_sync_dut%0d", tag, d), sync_w[d], 0);
            check($sformatf("%s_out_valid_dut%0d", tag, d), ov_w[d], 0);
            check($sformatf("%s_out_sync_dut%0d", tag, d), os_w[d], 0);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        freq_load_i   = 0;
        offset_load_i = 0;
        en_i          = 0;
        sync_i        = 0;
        freq_i        = '0;
        offset_i      = '0;
        rst_ni        = 1'b1;
        model_reset();
        tick();
        mon_on = 1;
    endtask

    // Reset held with random inputs: outputs must stay at zero throughout.
    task automatic held_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            drive_random();
            #1;
            check_zero("in_reset");
        end
        release_reset();
    endtask

    // ---------------- monitor ----------------
    // Each cycle: compare per-cycle expectations; on valid_o pop a sample.
    always @(negedge clk) begin
        if (mon_on) begin
            for (int d = 0; d < 2; d++) begin
                logic [18:0] e;
                logic [16:0] s;
                if (cyc_q[d].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL cycle_queue_empty_dut%0d at %0t", d, $time);
                end else begin
                    e = cyc_q[d].pop_front();
                    check($sformatf("valid_o_dut%0d", d), valid_w[d], e[18]);
                    check($sformatf("phase_held_dut%0d", d), {quad_w[d], ang_w[d]}, e[17:2]);
                    check($sformatf("out_valid_o_dut%0d", d), ov_w[d], e[1]);
                    check($sformatf("out_sync_o_dut%0d", d), os_w[d], e[0]);
                end
                if (valid_w[d]) begin
                    if (samp_q[d].size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_sample_dut%0d at %0t", d, $time);
                    end else begin
                        s = samp_q[d].pop_front();
                        check($sformatf("sample_phase_dut%0d", d), {quad_w[d], ang_w[d]}, s[15:0]);
                        check($sformatf("sample_sync_dut%0d", d), sync_w[d], s[16]);
                    end
                end else begin
                    check($sformatf("sync_o_idle_dut%0d", d), sync_w[d], 0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        freq_i = '0; offset_i = '0;
        freq_load_i = 0; offset_load_i = 0; en_i = 0; sync_i = 0;
        #2 rst_ni = 1'b0;
        held_reset(5);

        // Ramp of one angle LSB per sample.
        cyc(1, 32'h0001_0000, 1, 32'h0, 0, 0);
        repeat (40) cyc(0, 0, 0, 0, 1, 0);

        // Quadrant boundary 0 -> 1, then full-phase wrap 0xFFFF -> 0x0000.
        cyc(0, 0, 1, 32'h3FFE_0000, 0, 1);
        repeat (6) cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 32'hFFFD_0000, 0, 1);
        repeat (6) cyc(0, 0, 0, 0, 1, 0);

        // Fixed offset with zero frequency; the load cycle keeps the old offset.
        cyc(1, 32'h0, 0, 0, 1, 0);
        cyc(0, 0, 1, 32'h4000_0000, 1, 0);
        repeat (5) cyc(0, 0, 0, 0, 1, 0);

        // Half-LSB frequency: shows truncation versus rounding.
        cyc(1, 32'h0000_8000, 1, 32'h0, 0, 1);
        repeat (12) cyc(0, 0, 0, 0, 1, 0);

        // Sync mid-ramp with and without a sample in the same cycle.
        cyc(1, 32'h0001_0000, 0, 0, 0, 0);
        repeat (8) cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 1);
        repeat (4) cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 1, 0);

        // Gapped enable 1,0,0,1 from a restart.
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        repeat (LAT0 + 3) cyc(0, 0, 0, 0, 0, 0);

        rand_cycles(400);

        // Asynchronous reset between edges, mid-run.
        @(posedge clk);
        #3;
        rst_ni = 1'b0;
        mon_on = 0;
        #1;
        check_zero("async_reset");
        held_reset(3);
        rand_cycles(200);

        repeat (LAT0 + 3) cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        mon_on = 0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("samples_left_dut%0d", d), samp_q[d].size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
